// File: rtl/pkt_output_drain_pkg.sv
// Shared types for the packet-buffer drain stage.
//   flit_t     : one packet-buffer word {sop, eop, empty[5:0], data[511:0]}
//   metadata_t : per-packet descriptor {pkt_id, flits}; flits==0 encodes 32
//   drain_state_t : drain FSM states
//   flit_count()  : decodes the flits field into a real count (1..32)
package pkt_output_drain_pkg;

  localparam int PKT_AWIDTH    = 9;
  localparam int PKTBUF_AWIDTH = PKT_AWIDTH + 5;
  localparam int FLITS_W       = 5;
  localparam int MAX_FLITS     = 1 << FLITS_W;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    logic [511:0] data;
  } flit_t;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [FLITS_W-1:0]    flits;
  } metadata_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DROP,
    ST_FREE
  } drain_state_t;

  // A full 2 KB slot holds 32 flits, which does not fit the 5-bit field,
  // so the field value 0 stands for 32.
  function automatic logic [FLITS_W:0] flit_count(input logic [FLITS_W-1:0] flits);
    if (flits == '0)
      return (FLITS_W + 1)'(MAX_FLITS);
    return {1'b0, flits};
  endfunction

endpackage

// File: rtl/pkt_output_drain_fifo.sv
// out_flit_fifo: synchronous show-ahead FIFO of flit_t.
//   push/push_data : write side (caller guarantees no overflow)
//   pop            : consume head (ignored when empty)
//   head           : current head flit, valid whenever !empty
//   empty, count   : occupancy
// Pointers are PW bits wide so they wrap modulo DEPTH by overflow.
module out_flit_fifo
  import pkt_output_drain_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  flit_t                    push_data,
  input  logic                     pop,
  output flit_t                    head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  flit_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic            do_pop;

  assign do_pop = pop && (count_reg != '0);
  assign empty  = (count_reg == '0);
  assign count  = count_reg;
  // Show-ahead: the head is read combinationally so out_valid and the data
  // appear in the same cycle as the count becomes non-zero.
  assign head   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !do_pop)
      assert (count_reg != (PW + 1)'(DEPTH))
        else $error("out_flit_fifo overflow");
  end

endmodule

// File: rtl/pkt_output_drain.sv
// pkt_output_drain: drains forwarded packets from the packet buffer into a
// backpressured flit stream and returns every pktID to the free list.
//   meta_*          : per-packet descriptor + drop verdict (accepted in IDLE)
//   pkt_buffer_*    : read port, data valid RD_LAT cycles after the strobe
//   out_*           : flit stream from the output FIFO head
//   emptylist_in_*  : freed pktID handshake
// Reads are issued only against FIFO credit (queued + in flight), so the
// read pipeline itself never has to stall.
module pkt_output_drain
  import pkt_output_drain_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     meta_valid,
  input  metadata_t                meta_data,
  input  logic                     meta_drop,
  output logic                     meta_ready,
  output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
  output logic                     pkt_buffer_read,
  input  flit_t                    pkt_buffer_readdata,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [511:0]             out_data,
  output logic [5:0]               out_empty,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKT_AWIDTH-1:0]    emptylist_in_data,
  output logic                     emptylist_in_valid,
  input  logic                     emptylist_in_ready
);

  drain_state_t              state_reg, state_next;
  logic [PKT_AWIDTH-1:0]     pkt_id_reg, pkt_id_next;
  logic [FLITS_W:0]          n_reg, n_next;
  logic [FLITS_W:0]          idx_reg, idx_next;
  logic [FLITS_W:0]          land_idx_reg;
  logic [RD_LAT-1:0]         rd_vld_reg;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  flit_t                     fifo_head;
  logic                      credit_ok;
  logic                      issue;
  logic                      idle_ready;
  logic                      free_req;
  logic                      meta_accept;

  assign credit_ok = (int'(fifo_count) + $countones(rd_vld_reg)) < FIFO_DEPTH;
  assign fifo_push = rd_vld_reg[RD_LAT-1];

  always_comb begin
    state_next  = state_reg;
    pkt_id_next = pkt_id_reg;
    n_next      = n_reg;
    idx_next    = idx_reg;
    idle_ready  = 1'b0;
    issue       = 1'b0;
    free_req    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        idle_ready = 1'b1;
        if (meta_valid) begin
          pkt_id_next = meta_data.pkt_id;
          n_next      = flit_count(meta_data.flits);
          idx_next    = '0;
          state_next  = meta_drop ? ST_DROP : ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          issue    = 1'b1;
          idx_next = idx_reg + 1'b1;
          if (idx_reg == n_reg - 1'b1)
            state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The FIFO entry count only covers flits that have landed.
        if (rd_vld_reg == '0)
          state_next = ST_FREE;
      end
      ST_DROP: state_next = ST_FREE;
      ST_FREE: begin
        free_req = 1'b1;
        if (emptylist_in_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign meta_accept = idle_ready && meta_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rd_vld_reg   <= '0;
      land_idx_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rd_vld_reg <= (rd_vld_reg << 1) | RD_LAT'(issue);
      if (meta_accept)
        land_idx_reg <= '0;
      else if (fifo_push)
        land_idx_reg <= land_idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pkt_id_reg <= pkt_id_next;
    n_reg      <= n_next;
    idx_reg    <= idx_next;
  end

  // Framing checks on every landed flit of the current packet.
  always_ff @(posedge clk) begin
    if (!rst && fifo_push) begin
      if (land_idx_reg == '0)
        assert (pkt_buffer_readdata.sop) else $error("flit 0 without sop");
      if (land_idx_reg == n_reg - 1'b1)
        assert (pkt_buffer_readdata.eop) else $error("last flit without eop");
      else
        assert (!pkt_buffer_readdata.eop) else $error("early eop");
    end
  end

  out_flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (pkt_buffer_readdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Valid/ready outputs are forced low while reset is held.
  assign meta_ready         = idle_ready && !rst;
  assign pkt_buffer_read    = issue && !rst;
  assign pkt_buffer_address = {pkt_id_reg, idx_reg[FLITS_W-1:0]};
  assign out_valid          = !fifo_empty && !rst;
  assign fifo_pop           = out_valid && out_ready;
  assign out_sop            = fifo_head.sop;
  assign out_eop            = fifo_head.eop;
  assign out_empty          = fifo_head.empty;
  assign out_data           = fifo_head.data;
  assign emptylist_in_valid = free_req && !rst;
  assign emptylist_in_data  = pkt_id_reg;

endmodule

// File: tb/tb_pkt_output_drain.sv
// Scoreboard bench for pkt_output_drain: expected read addresses, output
// flits and freed pktIDs are queued when a packet is loaded and checked as
// the DUT produces them.
module tb_pkt_output_drain;
  import pkt_output_drain_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 8;
  typedef logic [519:0] cv_t;

  logic                     clk;
  logic                     rst;
  logic                     meta_valid;
  metadata_t                meta_data;
  logic                     meta_drop;
  logic                     meta_ready;
  logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
  logic                     pkt_buffer_read;
  flit_t                    pkt_buffer_readdata;
  logic                     out_sop;
  logic                     out_eop;
  logic [511:0]             out_data;
  logic [5:0]               out_empty;
  logic                     out_valid;
  logic                     out_ready;
  logic [PKT_AWIDTH-1:0]    emptylist_in_data;
  logic                     emptylist_in_valid;
  logic                     emptylist_in_ready;

  int vectors = 0;
  int miscompares = 0;
  int rd_count = 0;
  int beat_count = 0;
  int free_count = 0;

  flit_t mem [int];
  flit_t exp_q [$];
  int    addr_q [$];
  int    free_q [$];
  flit_t rd_pipe [RD_LAT];

  pkt_output_drain #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .meta_valid          (meta_valid),
    .meta_data           (meta_data),
    .meta_drop           (meta_drop),
    .meta_ready          (meta_ready),
    .pkt_buffer_address  (pkt_buffer_address),
    .pkt_buffer_read     (pkt_buffer_read),
    .pkt_buffer_readdata (pkt_buffer_readdata),
    .out_sop             (out_sop),
    .out_eop             (out_eop),
    .out_data            (out_data),
    .out_empty           (out_empty),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .emptylist_in_data   (emptylist_in_data),
    .emptylist_in_valid  (emptylist_in_valid),
    .emptylist_in_ready  (emptylist_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input cv_t got, input cv_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mem_read(input int a);
    if (mem.exists(a))
      return mem[a];
    return '0;
  endfunction

  // Packet buffer model with RD_LAT cycles of read latency.
  always @(posedge clk) begin
    rd_pipe[0] <= pkt_buffer_read ? mem_read(int'(pkt_buffer_address)) : '0;
    for (int i = 1; i < RD_LAT; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end
  assign pkt_buffer_readdata = rd_pipe[RD_LAT-1];

  // Monitor: one line per observed transaction, compared against the queues.
  always @(negedge clk) begin
    flit_t got;
    if (!rst) begin
      if (pkt_buffer_read) begin
        rd_count++;
        $display("[%0t] read  addr=%0d", $time, pkt_buffer_address);
        if (addr_q.size() > 0)
          check_val("rd_addr", cv_t'(pkt_buffer_address), cv_t'(addr_q.pop_front()));
        else
          check_val("rd_unexpected", cv_t'(1), cv_t'(0));
      end
      if (out_valid && out_ready) begin
        beat_count++;
        got = {out_sop, out_eop, out_empty, out_data};
        $display("[%0t] beat  sop=%0d eop=%0d empty=%0d data[31:0]=%h", $time,
                 out_sop, out_eop, out_empty, out_data[31:0]);
        if (exp_q.size() > 0)
          check_val("out_flit", cv_t'(got), cv_t'(exp_q.pop_front()));
        else
          check_val("out_unexpected", cv_t'(1), cv_t'(0));
      end
      if (emptylist_in_valid && emptylist_in_ready) begin
        free_count++;
        $display("[%0t] free  pkt_id=%0d", $time, emptylist_in_data);
        if (free_q.size() > 0)
          check_val("free_id", cv_t'(emptylist_in_data), cv_t'(free_q.pop_front()));
        else
          check_val("free_unexpected", cv_t'(1), cv_t'(0));
      end
    end
  end

  // Writes the packet into the buffer model and queues the expectations.
  task automatic load_pkt(input int pid, input int n, input logic [5:0] emp, input bit drop);
    flit_t f;
    for (int i = 0; i < n; i++) begin
      f.sop   = (i == 0);
      f.eop   = (i == n - 1);
      f.empty = (i == n - 1) ? emp : 6'd0;
      for (int w = 0; w < 16; w++)
        f.data[w*32 +: 32] = $urandom;
      mem[pid * 32 + i] = f;
      if (!drop) begin
        exp_q.push_back(f);
        addr_q.push_back(pid * 32 + i);
      end
    end
    free_q.push_back(pid);
  endtask

  // Presents one metadata beat and returns just after the accepting edge.
  task automatic send_meta(input int pid, input int n, input bit drop);
    bit done = 0;
    @(posedge clk); #1;
    meta_valid       = 1'b1;
    meta_data.pkt_id = PKT_AWIDTH'(pid);
    meta_data.flits  = FLITS_W'(n);   // 32 truncates to the 0 encoding
    meta_drop        = drop;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (meta_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    meta_valid = 1'b0;
    meta_drop  = 1'b0;
    if (!done)
      check_val("meta_accept_timeout", cv_t'(0), cv_t'(1));
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && addr_q.size() == 0 && free_q.size() == 0 && meta_ready)
        done = 1;
    end
    if (!done)
      check_val("drain_timeout", cv_t'(0), cv_t'(1));
  endtask

  initial begin
    int rd0, bt0, fr0, lat, cyc;
    int rd_first, rd_last, ov_first, ov_last, rds, ovs;
    bit seen;

    rst = 1'b1; meta_valid = 1'b0; meta_data = '0; meta_drop = 1'b0;
    out_ready = 1'b1; emptylist_in_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_meta_ready", cv_t'(meta_ready), cv_t'(0));
    check_val("rst_rd", cv_t'(pkt_buffer_read), cv_t'(0));
    check_val("rst_out_valid", cv_t'(out_valid), cv_t'(0));
    check_val("rst_free_valid", cv_t'(emptylist_in_valid), cv_t'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("idle_meta_ready", cv_t'(meta_ready), cv_t'(1));

    // Single flit, latency from accept to first out_valid
    load_pkt(5, 1, 6'd10, 0);
    send_meta(5, 1, 0);
    lat = 0; seen = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; seen = 1; end
    end
    check_val("latency", cv_t'(lat), cv_t'(RD_LAT + 2));
    wait_idle();

    // Three flits: consecutive reads and back-to-back beats
    load_pkt(3, 3, 6'd0, 0);
    send_meta(3, 3, 0);
    rds = 0; ovs = 0; rd_first = -1; rd_last = -1; ov_first = -1; ov_last = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pkt_buffer_read) begin rds++; if (rd_first < 0) rd_first = c; rd_last = c; end
      if (out_valid) begin ovs++; if (ov_first < 0) ov_first = c; ov_last = c; end
    end
    check_val("b2b_reads", cv_t'(rds), cv_t'(3));
    check_val("b2b_read_span", cv_t'(rd_last - rd_first), cv_t'(2));
    check_val("b2b_beats", cv_t'(ovs), cv_t'(3));
    check_val("b2b_beat_span", cv_t'(ov_last - ov_first), cv_t'(2));
    wait_idle();

    // Backpressure: credit limits issue to FIFO_DEPTH reads
    out_ready = 1'b0;
    rd0 = rd_count; bt0 = beat_count; fr0 = free_count;
    load_pkt(7, 20, 6'd33, 0);
    send_meta(7, 20, 0);
    repeat (30) @(posedge clk);
    #1;
    check_val("bp_reads", cv_t'(rd_count - rd0), cv_t'(FIFO_DEPTH));
    check_val("bp_valid_held", cv_t'(out_valid), cv_t'(1));
    out_ready = 1'b1;
    wait_idle();
    check_val("bp_beats", cv_t'(beat_count - bt0), cv_t'(20));
    check_val("bp_frees", cv_t'(free_count - fr0), cv_t'(1));

    // Drop: no reads, no beats, free two cycles after accept
    rd0 = rd_count; bt0 = beat_count;
    load_pkt(9, 12, 6'd0, 1);
    send_meta(9, 12, 1);
    cyc = 0; seen = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      if (emptylist_in_valid) begin cyc = c; seen = 1; end
    end
    check_val("drop_free_lat", cv_t'(cyc), cv_t'(2));
    wait_idle();
    check_val("drop_reads", cv_t'(rd_count - rd0), cv_t'(0));
    check_val("drop_beats", cv_t'(beat_count - bt0), cv_t'(0));

    // Max size (flits=0) with a stalled free list
    bt0 = beat_count; rd0 = rd_count;
    emptylist_in_ready = 1'b0;
    load_pkt(511, 32, 6'd5, 0);
    send_meta(511, 32, 0);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (emptylist_in_valid) seen = 1;
    end
    check_val("max_free_seen", cv_t'(seen), cv_t'(1));
    for (int c = 0; c < 10; c++) begin
      check_val("stall_free_valid", cv_t'(emptylist_in_valid), cv_t'(1));
      check_val("stall_free_id", cv_t'(emptylist_in_data), cv_t'(511));
      check_val("stall_meta_ready", cv_t'(meta_ready), cv_t'(0));
      @(negedge clk);
    end
    emptylist_in_ready = 1'b1;
    wait_idle();
    check_val("max_reads", cv_t'(rd_count - rd0), cv_t'(32));
    check_val("max_beats", cv_t'(beat_count - bt0), cv_t'(32));

    // Reset during beat 4 of 10: abandon, no free, then a clean packet
    bt0 = beat_count; fr0 = free_count;
    load_pkt(12, 10, 6'd0, 0);
    send_meta(12, 10, 0);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      if (beat_count - bt0 >= 4) seen = 1;
    end
    check_val("rst_mid_reached", cv_t'(seen), cv_t'(1));
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete(); addr_q.delete(); free_q.delete();
    @(negedge clk);
    check_val("mid_out_valid", cv_t'(out_valid), cv_t'(0));
    check_val("mid_rd", cv_t'(pkt_buffer_read), cv_t'(0));
    check_val("mid_free_valid", cv_t'(emptylist_in_valid), cv_t'(0));
    check_val("mid_idle", cv_t'(meta_ready), cv_t'(1));
    repeat (5) @(negedge clk);
    check_val("mid_no_free", cv_t'(free_count - fr0), cv_t'(0));
    bt0 = beat_count;
    load_pkt(20, 4, 6'd2, 0);
    send_meta(20, 4, 0);
    wait_idle();
    check_val("post_rst_beats", cv_t'(beat_count - bt0), cv_t'(4));
    check_val("post_rst_frees", cv_t'(free_count - fr0), cv_t'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
